// File: rtl/transmissor_ascii_n.sv
// Multi-character ASCII asynchronous serial transmitter.
// One partida pulse in INICIAL latches NCHAR 7-bit characters and sends them
// back-to-back, LSB first: start, d0..d6, optional parity, STOP_BITS stops.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   partida         start request (accepted only when not transmitting)
//   dados           message, character k = dados[7k+6:7k], k=0 sent first
//   saida_serial    serial line, idle high
//   ocupado         high while a message is in flight
//   pronto          one-cycle pulse after the last stop bit
//   db_indice       index of the character being sent
//   db_estado       FSM state code
module transmissor_ascii_n #(
    parameter int unsigned NCHAR        = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARIDADE     = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     partida,
    input  logic [7*NCHAR-1:0]       dados,
    output logic                     saida_serial,
    output logic                     ocupado,
    output logic                     pronto,
    output logic [$clog2(NCHAR):0]   db_indice,
    output logic [2:0]               db_estado
);

    localparam int unsigned BITS   = 8 + ((PARIDADE != 0) ? 1 : 0) + STOP_BITS;
    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(BITS);
    localparam int unsigned IDX_W  = $clog2(NCHAR) + 1;
    localparam int unsigned MSG_W  = 7 * NCHAR;

    // PROXIMO keeps its code but is folded into the last stop-bit cycle.
    typedef enum logic [2:0] {
        INICIAL   = 3'd0,
        TRANSMITE = 3'd1,
        PROXIMO   = 3'd2,
        FINAL     = 3'd3
    } estado_t;

    estado_t             estado, estado_n;
    logic [MSG_W-1:0]    msg, msg_n;
    logic [IDX_W-1:0]    indice, indice_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n;
    logic [6:0]          car_n;
    logic                saida_n, ocupado_n, pronto_n;

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= INICIAL;
            msg          <= '0;
            indice       <= '0;
            bit_cnt      <= '0;
            tick_cnt     <= '0;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            estado       <= estado_n;
            msg          <= msg_n;
            indice       <= indice_n;
            bit_cnt      <= bit_n;
            tick_cnt     <= tick_n;
            saida_serial <= saida_n;
            ocupado      <= ocupado_n;
            pronto       <= pronto_n;
        end
    end

    // Next state, counters, and the output values for the next cycle.
    always_comb begin
        estado_n  = estado;
        msg_n     = msg;
        indice_n  = indice;
        bit_n     = bit_cnt;
        tick_n    = tick_cnt;
        car_n     = 7'h7f;
        saida_n   = 1'b1;
        ocupado_n = 1'b0;
        pronto_n  = 1'b0;

        case (estado)
            // FINAL accepts a new request on its closing edge so a held
            // partida restarts on the very next cycle.
            INICIAL, FINAL: begin
                estado_n = INICIAL;
                if (partida) begin
                    estado_n = TRANSMITE;
                    msg_n    = dados;
                    indice_n = '0;
                    bit_n    = '0;
                    tick_n   = '0;
                end
            end
            TRANSMITE: begin
                if (tick_cnt == TICK_W'(CLKS_PER_BIT - 1)) begin
                    tick_n = '0;
                    if (bit_cnt == BIT_W'(BITS - 1)) begin
                        bit_n = '0;
                        if (indice == IDX_W'(NCHAR - 1)) begin
                            estado_n = FINAL;
                        end else begin
                            indice_n = indice + IDX_W'(1);
                        end
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    tick_n = tick_cnt + TICK_W'(1);
                end
            end
            default: estado_n = INICIAL;
        endcase

        // Character addressed by the next index.
        for (int unsigned k = 0; k < NCHAR; k++) begin
            if (indice_n == IDX_W'(k)) begin
                car_n = msg_n[7*k +: 7];
            end
        end

        // Line value of frame bit bit_n for that character.
        if (estado_n == TRANSMITE) begin
            if (bit_n == BIT_W'(0)) begin
                saida_n = 1'b0;
            end else if (bit_n <= BIT_W'(7)) begin
                saida_n = car_n[3'(bit_n - BIT_W'(1))];
            end else if ((PARIDADE != 0) && (bit_n == BIT_W'(8))) begin
                saida_n = (PARIDADE == 1) ? ~^car_n : ^car_n;
            end else begin
                saida_n = 1'b1;
            end
        end

        ocupado_n = (estado_n == TRANSMITE);
        pronto_n  = (estado_n == FINAL);
    end

    assign db_indice = indice;
    assign db_estado = estado;

endmodule

// File: tb/tb_transmissor_ascii_n.sv
// Self-checking bench for transmissor_ascii_n: three instances with different
// framing parameters, each compared cycle by cycle against a timing model.
module tb_transmissor_ascii_n;

    localparam int NA = 4, CA = 4, PA = 2, SA = 2;
    localparam int NB = 1, CB = 4, PB = 1, SB = 1;
    localparam int NC = 3, CC = 3, PC = 0, SC = 1;

    typedef struct packed {
        logic       line;
        logic       busy;
        logic       done;
        logic [2:0] idx;
        logic [2:0] st;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic         partida_a = 1'b0, partida_b = 1'b0, partida_c = 1'b0;
    logic [27:0]  dados_a = '0;
    logic [6:0]   dados_b = '0;
    logic [20:0]  dados_c = '0;
    logic         saida_a, saida_b, saida_c;
    logic         ocupado_a, ocupado_b, ocupado_c;
    logic         pronto_a, pronto_b, pronto_c;
    logic [2:0]   indice_a, indice_c;
    logic [0:0]   indice_b;
    logic [2:0]   estado_a, estado_b, estado_c;

    int nch [3] = '{NA, NB, NC};
    int cpb [3] = '{CA, CB, CC};
    int par [3] = '{PA, PB, PC};
    int stp [3] = '{SA, SB, SC};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    transmissor_ascii_n #(.NCHAR(NA), .CLKS_PER_BIT(CA), .PARIDADE(PA), .STOP_BITS(SA)) u_a (
        .clock(clock), .reset(reset), .partida(partida_a), .dados(dados_a),
        .saida_serial(saida_a), .ocupado(ocupado_a), .pronto(pronto_a),
        .db_indice(indice_a), .db_estado(estado_a));

    transmissor_ascii_n #(.NCHAR(NB), .CLKS_PER_BIT(CB), .PARIDADE(PB), .STOP_BITS(SB)) u_b (
        .clock(clock), .reset(reset), .partida(partida_b), .dados(dados_b),
        .saida_serial(saida_b), .ocupado(ocupado_b), .pronto(pronto_b),
        .db_indice(indice_b), .db_estado(estado_b));

    transmissor_ascii_n #(.NCHAR(NC), .CLKS_PER_BIT(CC), .PARIDADE(PC), .STOP_BITS(SC)) u_c (
        .clock(clock), .reset(reset), .partida(partida_c), .dados(dados_c),
        .saida_serial(saida_c), .ocupado(ocupado_c), .pronto(pronto_c),
        .db_indice(indice_c), .db_estado(estado_c));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, want);
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        case (d)
            0: begin o.line = saida_a; o.busy = ocupado_a; o.done = pronto_a; o.idx = indice_a; o.st = estado_a; end
            1: begin o.line = saida_b; o.busy = ocupado_b; o.done = pronto_b; o.idx = {2'b00, indice_b}; o.st = estado_b; end
            default: begin o.line = saida_c; o.busy = ocupado_c; o.done = pronto_c; o.idx = indice_c; o.st = estado_c; end
        endcase
        return o;
    endfunction

    task automatic drive(input int d, input logic p, input logic [447:0] m);
        case (d)
            0: begin partida_a = p; dados_a = m[27:0]; end
            1: begin partida_b = p; dados_b = m[6:0]; end
            default: begin partida_c = p; dados_c = m[20:0]; end
        endcase
    endtask

    task automatic start(input int d, input logic [447:0] m);
        drive(d, 1'b1, m);
        step();
        drive(d, 1'b0, m);
    endtask

    function automatic logic [447:0] rand_msg(input int d);
        logic [447:0] r;
        r = '0;
        for (int i = 0; i < nch[d]; i++) r[7*i +: 7] = 7'($urandom_range(126, 32));
        return r;
    endfunction

    function automatic int frame_bits(input int d);
        return 8 + ((par[d] != 0) ? 1 : 0) + stp[d];
    endfunction

    // Expected line level t cycles after the accepting edge.
    function automatic logic model_line(input logic [447:0] m, input int t, input int d);
        int bits, k, j, ones;
        logic [6:0] ch;
        bits = frame_bits(d);
        k    = t / (bits * cpb[d]);
        j    = (t / cpb[d]) % bits;
        ch   = m[7*k +: 7];
        ones = $countones(ch);
        if (j == 0) return 1'b0;
        if (j <= 7) return ch[j-1];
        if (j == 8 && par[d] == 1) return (ones % 2 == 0);
        if (j == 8 && par[d] == 2) return (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic check_idle(input int d, input int t);
        obs_t o;
        o = sample(d);
        chk("idle_line", t, o.line, 1);
        chk("idle_busy", t, o.busy, 0);
        chk("idle_pronto", t, o.done, 0);
    endtask

    // Walk one message from offset 0 to its pronto cycle; optionally disturb
    // partida/dados at dist_at or reset at abort_at.
    task automatic expect_msg(input int d, input logic [447:0] m, input int dist_at, input int abort_at);
        int bits, total;
        logic [447:0] junk;
        obs_t o;
        bits  = frame_bits(d);
        total = nch[d] * bits * cpb[d];
        junk  = '0;
        for (int t = 0; t <= total; t++) begin
            o = sample(d);
            if (t < total) begin
                chk("line", t, o.line, model_line(m, t, d));
                chk("busy", t, o.busy, 1);
                chk("pronto_low", t, o.done, 0);
                chk("indice", t, o.idx, t / (bits * cpb[d]));
                chk("estado_tx", t, o.st, 1);
            end else begin
                chk("pronto_high", t, o.done, 1);
                chk("pronto_busy", t, o.busy, 0);
                chk("pronto_line", t, o.line, 1);
                chk("estado_final", t, o.st, 3);
            end
            if (t == abort_at) begin
                reset = 1'b1;
                step();
                o = sample(d);
                chk("rst_line", t, o.line, 1);
                chk("rst_busy", t, o.busy, 0);
                chk("rst_pronto", t, o.done, 0);
                chk("rst_indice", t, o.idx, 0);
                chk("rst_estado", t, o.st, 0);
                reset = 1'b0;
                return;
            end
            if (dist_at >= 0 && t == dist_at) begin
                junk = rand_msg(d);
                drive(d, 1'b1, junk);
            end
            if (dist_at >= 0 && t == dist_at + 1) drive(d, 1'b0, junk);
            if (t < total) step();
        end
    endtask

    initial begin
        logic [447:0] m, m2;
        logic exp_b [10];
        obs_t o;
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset held three cycles, then idle with partida low.
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            o = sample(d);
            chk("reset_line", d, o.line, 1);
            chk("reset_busy", d, o.busy, 0);
            chk("reset_pronto", d, o.done, 0);
            chk("reset_indice", d, o.idx, 0);
            chk("reset_estado", d, o.st, 0);
        end
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            step();
            check_idle(0, t);
            o = sample(0);
            chk("idle_estado", t, o.st, 0);
        end
        check_idle(1, 20);
        check_idle(2, 20);

        // Single character '0' with odd parity, directed line sequence.
        m = '0;
        m[6:0] = 7'h30;
        start(1, m);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                o = sample(1);
                chk("b_line", 4*j + c, o.line, exp_b[j]);
                chk("b_pronto_low", 4*j + c, o.done, 0);
                step();
            end
        end
        o = sample(1);
        chk("b_pronto", 40, o.done, 1);
        step();
        for (int r = 0; r < 3; r++) begin
            m = rand_msg(1);
            start(1, m);
            expect_msg(1, m, -1, -1);
            step();
        end

        // Full message "180#" with even parity and two stop bits.
        m = '0;
        m[27:0] = {7'h23, 7'h30, 7'h38, 7'h31};
        start(0, m);
        expect_msg(0, m, -1, -1);
        step();
        for (int r = 0; r < 2; r++) begin
            m = rand_msg(0);
            start(0, m);
            expect_msg(0, m, -1, -1);
            step();
        end

        // New request and new data while busy leave the message untouched.
        m = rand_msg(0);
        start(0, m);
        expect_msg(0, m, 30, -1);
        for (int t = 0; t < 15; t++) begin
            step();
            check_idle(0, t);
        end

        // Reset during bit 3 of character 1, then a clean restart.
        m = rand_msg(0);
        start(0, m);
        expect_msg(0, m, -1, (11 + 3) * 4 + 1);
        for (int t = 0; t < 10; t++) begin
            step();
            check_idle(0, t);
        end
        m = rand_msg(0);
        start(0, m);
        expect_msg(0, m, -1, -1);
        step();

        // No parity, partida held high: second message follows pronto directly.
        m = rand_msg(2);
        drive(2, 1'b1, m);
        step();
        expect_msg(2, m, -1, -1);
        m2 = rand_msg(2);
        drive(2, 1'b1, m2);
        step();
        drive(2, 1'b0, m2);
        expect_msg(2, m2, -1, -1);
        for (int t = 0; t < 5; t++) begin
            step();
            check_idle(2, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
